// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Two-master round-robin arbiter between the CPU memory port (m0) and a
//   secondary bus master (m1), driving one address-decode bus (s_*).
//   Ownership is held for a whole transaction. Hung slave accesses are
//   completed after TIMEOUT_CYCLES with TIMEOUT_DATA and a sticky error flag.
//
//   state | meaning
//   IDLE  | no owner; arbitrate among valid masters
//   BUSY  | request forwarded to decode, waiting for s_ready or timeout
//   RESP  | one-cycle ready pulse with latched read data to the owner
//
// Ports
//   clk, reset           : clock, synchronous active-high reset
//   mX_valid/instr/addr/wdata/wstrb : master X request (X = 0 CPU, 1 secondary)
//   mX_rdata/ready       : master X response (ready is a one-cycle pulse)
//   s_valid/instr/addr/wdata/wstrb : forwarded request to address decode
//   s_rdata/ready        : decode response
//   grant                : current/last owner (0 = m0, 1 = m1)
//   timeout_err          : sticky timeout flag, cleared by clear_err
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_DATA   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  input  logic        s_ready,
  output logic        grant,
  output logic        timeout_err,
  input  logic        clear_err
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_e;

  state_e          state_q, state_d;
  logic            grant_q, grant_d;
  logic            last_grant_q, last_grant_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            terr_q, terr_d;
  logic            owner_valid;
  logic            timeout_hit;

  assign owner_valid = grant_q ? m1_valid : m0_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      timer_q      <= '0;
      rdata_q      <= '0;
      terr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      rdata_q      <= rdata_d;
      terr_q       <= terr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    rdata_d      = rdata_q;
    timeout_hit  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (m0_valid || m1_valid) begin
          // A lone requester wins outright; a tie goes to whoever did not own last.
          grant_d = (m0_valid && m1_valid) ? ~last_grant_q : m1_valid;
          timer_d = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!owner_valid) begin
          // Owner withdrew its request: drop silently but still rotate priority.
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end else if (s_ready) begin
          rdata_d = s_rdata;
          state_d = ST_RESP;
        end else if (timer_q == TIMER_LAST) begin
          rdata_d     = TIMEOUT_DATA;
          timeout_hit = 1'b1;
          state_d     = ST_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RESP: begin
        last_grant_d = grant_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Set beats clear when both land in the same cycle.
    terr_d = timeout_hit ? 1'b1 : (clear_err ? 1'b0 : terr_q);
  end

  always_comb begin
    s_valid  = 1'b0;
    s_instr  = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    if (state_q == ST_BUSY) begin
      s_valid = 1'b1;
      s_instr = grant_q ? m1_instr : m0_instr;
      s_addr  = grant_q ? m1_addr  : m0_addr;
      s_wdata = grant_q ? m1_wdata : m0_wdata;
      s_wstrb = grant_q ? m1_wstrb : m0_wstrb;
    end
    if (state_q == ST_RESP) begin
      m0_ready = ~grant_q;
      m1_ready = grant_q;
      m0_rdata = grant_q ? 32'h0 : rdata_q;
      m1_rdata = grant_q ? rdata_q : 32'h0;
    end
  end

  assign grant       = grant_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready;
  logic        s_valid, s_instr;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic        grant, timeout_err, clear_err;

  int tests = 0;
  int fails = 0;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(8), .TIMEOUT_DATA(32'h0)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata), .s_ready(s_ready),
    .grant(grant), .timeout_err(timeout_err), .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; checks follow once logic settles.
  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  // Called in a BUSY cycle: answer with s_ready now, then check the RESP cycle.
  task automatic serve(input logic g, input logic [31:0] addr, input logic [31:0] rd);
    chk1("busy_s_valid", s_valid, 1'b1);
    chk1("busy_grant", grant, g);
    chk32("busy_s_addr", s_addr, addr);
    s_ready = 1'b1;
    s_rdata = rd;
    nxt();
    s_ready = 1'b0;
    s_rdata = 32'h0;
    #1;
    chk1("resp_s_valid", s_valid, 1'b0);
    chk32("resp_s_addr", s_addr, 32'h0);
    chk1("resp_m0_ready", m0_ready, ~g);
    chk1("resp_m1_ready", m1_ready, g);
    chk32("resp_m0_rdata", m0_rdata, g ? 32'h0 : rd);
    chk32("resp_m1_rdata", m1_rdata, g ? rd : 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    s_rdata = 0; s_ready = 0; clear_err = 0;
    nxt(); nxt();
    reset = 1'b0;
    #1;
    chk1("rst_s_valid", s_valid, 1'b0);
    chk1("rst_grant", grant, 1'b0);
    chk1("rst_terr", timeout_err, 1'b0);
    chk1("rst_m0_ready", m0_ready, 1'b0);
    chk1("rst_m1_ready", m1_ready, 1'b0);

    // Single m0 read, decode answers one cycle after s_valid.
    m0_valid = 1; m0_instr = 1; m0_addr = 32'h4000_0010; m0_wstrb = 4'h0;
    nxt();
    chk1("t1_s_valid", s_valid, 1'b1);
    chk1("t1_s_instr", s_instr, 1'b1);
    chk32("t1_s_addr", s_addr, 32'h4000_0010);
    nxt();
    serve(1'b0, 32'h4000_0010, 32'hDEAD_BEEF);
    m0_valid = 0; m0_instr = 0;
    nxt();
    chk1("t1_m0_ready_single", m0_ready, 1'b0);
    chk1("t1_idle_s_valid", s_valid, 1'b0);

    // Simultaneous requests straight after reset: m0, m1, then m0 again.
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    m0_valid = 1; m0_addr = 32'h0000_1000;
    m1_valid = 1; m1_addr = 32'h0000_2000;
    nxt();
    serve(1'b0, 32'h0000_1000, 32'h1111_0000);
    nxt();
    chk1("t2_gap_s_valid", s_valid, 1'b0);
    nxt();
    serve(1'b1, 32'h0000_2000, 32'h2222_0000);
    m1_valid = 0;
    nxt();
    chk1("t2_gap2_s_valid", s_valid, 1'b0);
    nxt();
    serve(1'b0, 32'h0000_1000, 32'h3333_0000);
    m0_valid = 0;
    nxt();

    // m1 write with full strobes.
    m1_valid = 1; m1_addr = 32'h0000_3000; m1_wdata = 32'h1234_5678; m1_wstrb = 4'hF;
    nxt();
    chk32("t3_s_wdata", s_wdata, 32'h1234_5678);
    chk32("t3_s_wstrb", {28'h0, s_wstrb}, 32'h0000_000F);
    serve(1'b1, 32'h0000_3000, 32'h0BAD_F00D);
    chk32("t3_resp_s_wstrb", {28'h0, s_wstrb}, 32'h0);
    m1_valid = 0; m1_wstrb = 4'h0; m1_wdata = 0;
    nxt();
    chk1("t3_m1_ready_single", m1_ready, 1'b0);

    // Timeout: s_ready never arrives, eight BUSY cycles then forced completion.
    m0_valid = 1; m0_addr = 32'h0000_5000;
    for (int i = 0; i < 8; i++) begin
      nxt();
      chk1("t4_busy_s_valid", s_valid, 1'b1);
      chk1("t4_busy_m0_ready", m0_ready, 1'b0);
    end
    chk1("t4_terr_before", timeout_err, 1'b0);
    nxt();
    chk1("t4_resp_s_valid", s_valid, 1'b0);
    chk1("t4_resp_m0_ready", m0_ready, 1'b1);
    chk32("t4_resp_m0_rdata", m0_rdata, 32'h0);
    chk1("t4_terr_set", timeout_err, 1'b1);
    m0_valid = 0;
    nxt();

    // Second timeout with clear_err in the very cycle the timeout fires.
    m0_valid = 1;
    for (int i = 0; i < 8; i++) nxt();
    chk1("t4b_last_busy", s_valid, 1'b1);
    clear_err = 1;
    nxt();
    clear_err = 0;
    #1;
    chk1("t4b_resp_m0_ready", m0_ready, 1'b1);
    chk1("t4b_terr_set_wins", timeout_err, 1'b1);
    m0_valid = 0;
    nxt();
    clear_err = 1;
    nxt();
    clear_err = 0;
    #1;
    chk1("t4b_terr_cleared", timeout_err, 1'b0);

    // Reset while BUSY, with s_ready offered in that same cycle.
    m0_valid = 1; m0_addr = 32'h0000_6000;
    nxt();
    chk1("t5_busy", s_valid, 1'b1);
    s_ready = 1; s_rdata = 32'hCAFE_0001;
    reset = 1;
    nxt();
    chk1("t5_rst_s_valid", s_valid, 1'b0);
    chk32("t5_rst_s_addr", s_addr, 32'h0);
    chk1("t5_rst_m0_ready", m0_ready, 1'b0);
    chk32("t5_rst_m0_rdata", m0_rdata, 32'h0);
    chk1("t5_rst_grant", grant, 1'b0);
    reset = 0; s_ready = 0; s_rdata = 0;
    m1_valid = 1; m1_addr = 32'h0000_7000;
    nxt();
    serve(1'b0, 32'h0000_6000, 32'hCAFE_0002);
    m0_valid = 0;
    nxt();

    // Granted m1 aborts mid-BUSY; pending m0 is served next.
    m0_valid = 1; m0_addr = 32'h0000_8000;
    nxt();
    chk1("t6_busy_grant", grant, 1'b1);
    chk32("t6_busy_s_addr", s_addr, 32'h0000_7000);
    m1_valid = 0;
    nxt();
    chk1("t6_abort_s_valid", s_valid, 1'b0);
    chk1("t6_abort_m0_ready", m0_ready, 1'b0);
    chk1("t6_abort_m1_ready", m1_ready, 1'b0);
    chk1("t6_abort_terr", timeout_err, 1'b0);
    nxt();
    serve(1'b0, 32'h0000_8000, 32'hFACE_0003);
    m0_valid = 0;
    nxt();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
